// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: Moore-decoded datapath controls plus ALU decoder.
// Control outputs are registered alongside the state so every select is glitch-free.
module mips_multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2, MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       branch;
    logic       pcwrite;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BEQEX:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB:  c.regwrite = 1'b1;
      JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:
        case (op)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = RTYPEEX;
          6'b000100:            state_d = BEQEX;
          6'b001000:            state_d = ADDIEX;
          6'b000010:            state_d = JEX;
          default:              state_d = FETCH;
        endcase
      MEMADR:  state_d = (op == 6'b100011) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Controls are decoded from the next state so the registered copy matches state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ctrl_q  <= decode_state(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_state(state_d);
    end
  end

  always_comb begin
    alucontrol = 3'b010;
    case (ctrl_q.aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10:
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      default: alucontrol = 3'b010;
    endcase
  end

  assign iord     = ctrl_q.iord;
  assign memwrite = ctrl_q.memwrite;
  assign irwrite  = ctrl_q.irwrite;
  assign regdst   = ctrl_q.regdst;
  assign memtoreg = ctrl_q.memtoreg;
  assign regwrite = ctrl_q.regwrite;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;
  assign pcen     = ctrl_q.pcwrite | (ctrl_q.branch & zero);
  assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Randomized instruction-level bench for mips_multicycle_controller against a
// per-instruction state-path and per-state control-table model.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'h3f;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mips_multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .pcen(pcen), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: states an instruction walks through, keyed by opcode.
  function automatic void path_for(input logic [5:0] o, output int unsigned p[$]);
    case (o)
      6'b100011: p = '{0, 1, 2, 3, 4};
      6'b101011: p = '{0, 1, 2, 5};
      6'b000000: p = '{0, 1, 6, 7};
      6'b000100: p = '{0, 1, 8};
      6'b001000: p = '{0, 1, 9, 10};
      6'b000010: p = '{0, 1, 11};
      default:   p = '{0, 1};
    endcase
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Reference: each output as the set of states that assert it.
  function automatic logic [14:0] model_out(input int unsigned s, input logic [5:0] f, input logic z);
    logic e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_sa, e_pcen;
    logic [1:0] e_sb, e_ps;
    logic [2:0] e_alu;
    e_iord = (s == 3) || (s == 5);
    e_mw   = (s == 5);
    e_irw  = (s == 0);
    e_rd   = (s == 7);
    e_m2r  = (s == 4);
    e_rw   = (s == 4) || (s == 7) || (s == 10);
    e_sa   = (s == 2) || (s == 6) || (s == 8) || (s == 9);
    e_sb   = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : ((s == 2) || (s == 9)) ? 2'b10 : 2'b00;
    e_ps   = (s == 8) ? 2'b01 : (s == 11) ? 2'b10 : 2'b00;
    e_alu  = (s == 8) ? 3'b110 : (s == 6) ? rtype_alu(f) : 3'b010;
    e_pcen = (s == 0) || (s == 11) || ((s == 8) && z);
    return {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_sa, e_sb, e_ps, e_alu, e_pcen};
  endfunction

  function automatic logic [14:0] dut_out();
    return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, pcsrc, alucontrol, pcen};
  endfunction

  task automatic check_cycle(input string tag, input int unsigned s);
    check({tag, ".state"}, 32'(state), 32'(s));
    check({tag, ".ctrl"}, 32'(dut_out()), 32'(model_out(s, funct, zero)));
  endtask

  // Expects to be entered just before the negedge on which the DUT is in FETCH.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit force_zero,
                           input logic zval, input string tag);
    int unsigned p[$];
    path_for(o, p);
    foreach (p[i]) begin
      @(negedge clk);
      if (i == 0) begin
        op = o;
        funct = f;
      end
      zero = force_zero ? zval : 1'($urandom);
      #1 check_cycle(tag, p[i]);
    end
  endtask

  localparam logic [5:0] FUNCTS [6] = '{6'b100000, 6'b100010, 6'b100100,
                                         6'b100101, 6'b101010, 6'b111111};
  localparam logic [5:0] OPS [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                      6'b001000, 6'b000010, 6'b111111};

  initial begin
    logic [5:0] ro, rf;
    // Reset held for three cycles, outputs show the FETCH decode throughout.
    repeat (3) @(negedge clk);
    #1 check_cycle("reset_hold", 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_cycle("reset_rel", 0);
    @(negedge clk);
    #1 check_cycle("first_decode", 1);

    run_instr(6'b100011, 6'h00, 1'b0, 1'b0, "lw");
    run_instr(6'b101011, 6'h00, 1'b0, 1'b0, "sw");
    run_instr(6'b001000, 6'h00, 1'b0, 1'b0, "addi");
    foreach (FUNCTS[k]) run_instr(6'b000000, FUNCTS[k], 1'b0, 1'b0, "rtype");
    run_instr(6'b000100, 6'h00, 1'b1, 1'b1, "beq_taken");
    run_instr(6'b000100, 6'h00, 1'b1, 1'b0, "beq_not_taken");
    run_instr(6'b000010, 6'h00, 1'b0, 1'b0, "j");
    run_instr(6'b111111, 6'h00, 1'b0, 1'b0, "undef_op");

    // lw abandoned by a reset pulse while in MEMRD.
    begin
      int unsigned p[$];
      path_for(6'b100011, p);
      for (int unsigned i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 0) op = 6'b100011;
        zero = 1'($urandom);
        #1 check_cycle("lw_pre_reset", p[i]);
      end
      #1 rst_n = 1'b0;
      #1 check_cycle("mid_reset", 0);
      @(negedge clk);
      rst_n = 1'b1;
      op = 6'h3f;
      #1 check_cycle("mid_reset_rel", 0);
      @(negedge clk);
      #1 check_cycle("mid_reset_decode", 1);
    end

    for (int unsigned n = 0; n < 80; n++) begin
      ro = OPS[$urandom_range(6)];
      if ($urandom_range(7) == 0) ro = 6'($urandom);
      rf = ($urandom_range(3) == 0) ? 6'($urandom) : FUNCTS[$urandom_range(5)];
      run_instr(ro, rf, 1'b0, 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Control FSM for the multicycle MIPS datapath, directly upstream of the ALU. Each instruction is sequenced over 3–5 clock cycles. Every cycle the block drives all datapath mux selects and write enables, plus the 3-bit ALU operation code. It decodes opcode and funct from the instruction register and uses the ALU `zero` flag to resolve branches.

## Interface
- Parameters: none.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  6  instruction[31:26] from the instruction register; stable from DECODE onward.
- `funct`  in  6  instruction[5:0].
- `zero`  in  1  ALU zero flag, combinational from the current ALU result.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU-out register.
- `memwrite`  out  1  data memory write enable.
- `irwrite`  out  1  instruction register load enable.
- `regdst`  out  1  destination register select: 0 = rt, 1 = rd.
- `memtoreg`  out  1  write-back data select: 0 = ALU-out, 1 = memory data register.
- `regwrite`  out  1  register file write enable.
- `alusrca`  out  1  ALU srca select: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU srcb select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pcsrc`  out  2  PC source select: 00 = ALU result, 01 = ALU-out register, 10 = jump target.
- `alucontrol`  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `pcen`  out  1  PC load enable.
- `state`  out  4  current state, for debug.

## Operation
- State register is 4 bits. Encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11
- All outputs are Moore-decoded from `state`, except `pcen` = `pcwrite` | (`branch` & `zero`). `pcwrite` and `branch` are internal signals.
- An internal 2-bit `aluop` feeds the ALU decoder:
  - aluop 00 → alucontrol 010 (ADD).
  - aluop 01 → alucontrol 110 (SUB).
  - aluop 10 → decode `funct`: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct → 010.
- Per-state assertions (any output not listed is 0; `alusrcb`/`pcsrc` default to 00 and `aluop` to 00):
  - FETCH: alusrcb=01, irwrite, pcwrite.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca, alusrcb=10.
  - MEMRD: iord.
  - MEMWB: memtoreg, regwrite.
  - MEMWR: iord, memwrite.
  - RTYPEEX: alusrca, aluop=10.
  - RTYPEWB: regdst, regwrite.
  - BEQEX: alusrca, aluop=01, pcsrc=01, branch.
  - ADDIEX: alusrca, alusrcb=10.
  - ADDIWB: regwrite.
  - JEX: pcsrc=10, pcwrite.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by `op`: 100011 or 101011 → MEMADR; 000000 → RTYPEEX; 000100 → BEQEX; 001000 → ADDIEX; 000010 → JEX; any other → FETCH (executed as a NOP).
  - MEMADR → MEMRD if op=100011, else MEMWR.
  - MEMRD → MEMWB.
  - RTYPEEX → RTYPEWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX → FETCH.
- Encodings 12–15 are unreachable. If entered, they go to FETCH on the next clock and drive all outputs to 0.

## Timing
- `rst_n` low forces `state` to FETCH immediately, without waiting for a clock edge.
- While in reset, outputs equal the FETCH decode: irwrite=1, pcen=1, alusrcb=01, alucontrol=010, all others 0. The datapath registers are held in reset at the same time, so these enables have no effect.
- Reset may be asserted mid-instruction. A partially executed instruction is abandoned, and no write enable is asserted after reset assertion except as part of the FETCH decode.
- On `rst_n` release, the first rising edge moves FETCH → DECODE.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
- `pcen` in BEQEX follows `zero` combinationally within the same cycle. The PC loads at the end of BEQEX only if `zero`=1.
- `op` is sampled only in DECODE and MEMADR. `funct` is used only in RTYPEEX.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → state=0, irwrite=1, pcen=1, alucontrol=010. After 1 clock → state=1, alusrcb=11.
- lw (op=100011): state sequence 0,1,2,3,4. In state 2: alusrca=1, alusrcb=10. In state 3: iord=1. In state 4: regwrite=1, memtoreg=1. Then returns to 0.
- sw then addi: sw visits 0,1,2,5 with memwrite=1 only in state 5. addi visits 0,1,9,10 with regwrite=1, regdst=0 in state 10.
- R-type, funct sweep 100000/100010/100100/100101/101010/111111: in state 6, alucontrol = 010/110/000/001/111/010 respectively. In state 7: regdst=1, regwrite=1.
- beq (op=000100): with zero=1 → in state 8, alucontrol=110, pcsrc=01, pcen=1. Repeat with zero=0 → pcen=0. Next state is 0 in both cases.
- j (op=000010) → state 11 with pcsrc=10, pcen=1. Undefined op (op=111111) → DECODE returns to 0 with no write enable asserted. rst_n pulsed low during state 3 → state=0 immediately, memwrite=0, regwrite=0.
